inst_ram_loader: RTL and testbench

Touchscreen-driven writer for a word-addressed RAM; it is the write-side counterpart to the asynchronous instruction ROM viewer. The block takes values typed on the LCD touchscreen: a start address, then a burst length, then that many data words. It writes each word to the RAM and reads it back to verify it. It also drives the lcd_module display-slot interface so progress and errors appear on screen. It sits between lcd_module and a RAM that has a synchronous write port and an asynchronous read port.

---
 rtl/inst_ram_loader_pkg.sv | 30 +++
 rtl/inst_ram_loader_display.sv | 59 +++++
 rtl/inst_ram_loader.sv | 136 +++++++++++++
 tb/tb_inst_ram_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_ram_loader_pkg.sv
// Shared definitions for the touchscreen-driven RAM loader.
// Contents: FSM state encoding, display-slot indices and labels, default burst limit.
package inst_ram_loader_pkg;

  // Encoded values are shown on the STATE display slot, so they are fixed.
  typedef enum logic [2:0] {
    StAddr   = 3'd0,
    StLen    = 3'd1,
    StData   = 3'd2,
    StWrite  = 3'd3,
    StVerify = 3'd4
  } state_e;

  localparam int unsigned DefaultMaxLen = 16;

  localparam logic [5:0] SlotAddr  = 6'd1;
  localparam logic [5:0] SlotLeft  = 6'd2;
  localparam logic [5:0] SlotWdata = 6'd3;
  localparam logic [5:0] SlotRdata = 6'd4;
  localparam logic [5:0] SlotErrs  = 6'd5;
  localparam logic [5:0] SlotState = 6'd6;

  localparam logic [39:0] NameAddr  = "ADDR ";
  localparam logic [39:0] NameLeft  = "LEFT ";
  localparam logic [39:0] NameWdata = "WDATA";
  localparam logic [39:0] NameRdata = "RDATA";
  localparam logic [39:0] NameErrs  = "ERRS ";
  localparam logic [39:0] NameState = "STATE";

endpackage

// File: rtl/inst_ram_loader_display.sv
// Registered display-slot mux feeding lcd_module.
// Ports:
//   clk_i, resetn_i       clock, synchronous active-low reset
//   display_number_i      slot index requested by lcd_module
//   addr_i .. state_i     live loader values to show
//   display_valid_o/name_o/value_o  slot contents, one cycle after the request
module inst_ram_loader_display
  import inst_ram_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic [5:0]  display_number_i,
  input  logic [29:0] addr_i,
  input  logic [4:0]  left_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  input  logic [15:0] err_cnt_i,
  input  state_e      state_i,
  output logic        display_valid_o,
  output logic [39:0] display_name_o,
  output logic [31:0] display_value_o
);

  logic        valid_q, valid_d;
  logic [39:0] name_q, name_d;
  logic [31:0] value_q, value_d;

  always_comb begin
    valid_d = 1'b1;
    name_d  = '0;
    value_d = '0;
    unique case (display_number_i)
      SlotAddr:  begin name_d = NameAddr;  value_d = {addr_i, 2'b00};        end
      SlotLeft:  begin name_d = NameLeft;  value_d = {27'd0, left_i};        end
      SlotWdata: begin name_d = NameWdata; value_d = wdata_i;                end
      SlotRdata: begin name_d = NameRdata; value_d = rdata_i;                end
      SlotErrs:  begin name_d = NameErrs;  value_d = {16'd0, err_cnt_i};     end
      SlotState: begin name_d = NameState; value_d = {29'd0, 3'(state_i)};   end
      default:   valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      valid_q <= 1'b0;
      name_q  <= '0;
      value_q <= '0;
    end else begin
      valid_q <= valid_d;
      name_q  <= name_d;
      value_q <= value_d;
    end
  end

  assign display_valid_o = valid_q;
  assign display_name_o  = name_q;
  assign display_value_o = value_q;

endmodule

// File: rtl/inst_ram_loader.sv
// Touchscreen-driven RAM writer: takes a start address, a burst length and then
// that many data words, writes each word and reads it back to verify.
// Ports:
//   clk_i, resetn_i              clock, synchronous active-low reset
//   input_valid_i/input_value_i  one-cycle entry pulse and value from lcd_module
//   ram_we_o/ram_addr_o/ram_wdata_o/ram_rdata_i  RAM write port + async read port
//   busy_o                       high while writing or verifying
//   err_o                        sticky verify-mismatch flag
//   display_*                    lcd_module display-slot interface
module inst_ram_loader
  import inst_ram_loader_pkg::*;
#(
  parameter int unsigned MaxLen = DefaultMaxLen  // legal range 1..31
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        input_valid_i,
  input  logic [31:0] input_value_i,
  output logic        ram_we_o,
  output logic [29:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i,
  output logic        busy_o,
  output logic        err_o,
  input  logic [5:0]  display_number_i,
  output logic        display_valid_o,
  output logic [39:0] display_name_o,
  output logic [31:0] display_value_o
);

  localparam logic [4:0] MaxLenW = 5'(MaxLen);

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  left_q, left_d;
  logic        err_q, err_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q   <= StAddr;
      addr_q    <= '0;
      wdata_q   <= '0;
      left_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      left_q    <= left_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Next-state and datapath updates. input_valid_i is only looked at in the
  // entry states, so pulses during WRITE/VERIFY are simply lost.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    left_d    = left_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    unique case (state_q)
      StAddr: begin
        if (input_valid_i) begin
          addr_d  = input_value_i[31:2];
          state_d = StLen;
        end
      end
      StLen: begin
        if (input_valid_i) begin
          if (input_value_i == 32'd0) begin
            state_d = StAddr;
          end else begin
            left_d  = (input_value_i > 32'(MaxLen)) ? MaxLenW : input_value_i[4:0];
            state_d = StData;
          end
        end
      end
      StData: begin
        if (input_valid_i) begin
          wdata_d = input_value_i;
          state_d = StWrite;
        end
      end
      StWrite: begin
        state_d = StVerify;
      end
      StVerify: begin
        if (ram_rdata_i != wdata_q) begin
          err_d = 1'b1;
          if (err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
          end
        end
        addr_d  = addr_q + 30'd1;  // natural 30-bit wrap
        left_d  = left_q - 5'd1;
        state_d = (left_q != 5'd1) ? StData : StAddr;
      end
      default: begin
        state_d = StAddr;
      end
    endcase
  end

  // Outputs decoded from registered state only, so ram_we_o cannot glitch.
  always_comb begin
    ram_we_o = (state_q == StWrite);
    busy_o   = (state_q == StWrite) || (state_q == StVerify);
  end

  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;
  assign err_o       = err_q;

  inst_ram_loader_display u_display (
    .clk_i            (clk_i),
    .resetn_i         (resetn_i),
    .display_number_i (display_number_i),
    .addr_i           (addr_q),
    .left_i           (left_q),
    .wdata_i          (wdata_q),
    .rdata_i          (ram_rdata_i),
    .err_cnt_i        (err_cnt_q),
    .state_i          (state_q),
    .display_valid_o  (display_valid_o),
    .display_name_o   (display_name_o),
    .display_value_o  (display_value_o)
  );

endmodule

// File: tb/tb_inst_ram_loader.sv
module tb_inst_ram_loader;

  logic        clk = 1'b0;
  logic        resetn;
  logic        input_valid;
  logic [31:0] input_value;
  logic        ram_we;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        busy;
  logic        err;
  logic [5:0]  display_number;
  logic        display_valid;
  logic [39:0] display_name;
  logic [31:0] display_value;

  // Small RAM model: 32 words aliased on the low address bits.
  logic [31:0] mem [32];
  logic        corrupt;
  logic [29:0] wr_addr_log [$];
  logic [31:0] wr_data_log [$];

  int n_checks = 0;
  int n_pass   = 0;

  always #50 clk = ~clk;

  inst_ram_loader #(.MaxLen(16)) dut (
    .clk_i            (clk),
    .resetn_i         (resetn),
    .input_valid_i    (input_valid),
    .input_value_i    (input_value),
    .ram_we_o         (ram_we),
    .ram_addr_o       (ram_addr),
    .ram_wdata_o      (ram_wdata),
    .ram_rdata_i      (ram_rdata),
    .busy_o           (busy),
    .err_o            (err),
    .display_number_i (display_number),
    .display_valid_o  (display_valid),
    .display_name_o   (display_name),
    .display_value_o  (display_value)
  );

  assign ram_rdata = (corrupt && ram_addr == 30'd5) ? 32'hDEADBEEF : mem[ram_addr[4:0]];

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr[4:0]] <= ram_wdata;
      wr_addr_log.push_back(ram_addr);
      wr_data_log.push_back(ram_wdata);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One-cycle entry pulse, then idle long enough for any write/verify to finish.
  task automatic send(input logic [31:0] v);
    @(negedge clk);
    input_valid = 1'b1;
    input_value = v;
    @(negedge clk);
    input_valid = 1'b0;
    repeat (9) @(negedge clk);
  endtask

  task automatic show(input logic [5:0] slot);
    display_number = slot;
    @(negedge clk);
  endtask

  task automatic clear_log();
    wr_addr_log.delete();
    wr_data_log.delete();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    resetn = 1'b0; input_valid = 1'b0; input_value = '0;
    display_number = 6'd6; corrupt = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_we", 64'(ram_we), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_addr", 64'(ram_addr), 64'd0);
    check("rst_wdata", 64'(ram_wdata), 64'd0);
    check("rst_dvalid", 64'(display_valid), 64'd0);
    check("rst_dname", 64'(display_name), 64'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_state_valid", 64'(display_valid), 64'd1);
    check("rst_state_name", 64'(display_name), 64'("STATE"));
    check("rst_state_val", 64'(display_value), 64'd0);
    show(6'd0);
    check("slot0_valid", 64'(display_valid), 64'd0);
    check("slot0_val", 64'(display_value), 64'd0);
    show(6'd5);
    check("rst_errcnt", 64'(display_value), 64'd0);

    // Basic burst
    clear_log();
    send(32'h10); send(32'd3); send(32'hA); send(32'hB); send(32'hC);
    check("basic_nwr", 64'(wr_addr_log.size()), 64'd3);
    if (wr_addr_log.size() == 3) begin
      check("basic_a0", 64'(wr_addr_log[0]), 64'd4);
      check("basic_a1", 64'(wr_addr_log[1]), 64'd5);
      check("basic_a2", 64'(wr_addr_log[2]), 64'd6);
      check("basic_d0", 64'(wr_data_log[0]), 64'hA);
      check("basic_d1", 64'(wr_data_log[1]), 64'hB);
      check("basic_d2", 64'(wr_data_log[2]), 64'hC);
    end
    check("basic_err", 64'(err), 64'd0);
    show(6'd6);
    check("basic_state", 64'(display_value), 64'd0);
    show(6'd1);
    check("basic_addr_slot", 64'(display_value), 64'h1C);
    check("basic_addr_name", 64'(display_name), 64'("ADDR "));

    // Verify error at word 5
    corrupt = 1'b1;
    clear_log();
    send(32'h10); send(32'd3); send(32'h1);
    check("verr_err_pre", 64'(err), 64'd0);
    send(32'h2);
    check("verr_err", 64'(err), 64'd1);
    show(6'd5);
    check("verr_cnt", 64'(display_value), 64'd1);
    send(32'h3);
    check("verr_nwr", 64'(wr_addr_log.size()), 64'd3);
    if (wr_addr_log.size() == 3) check("verr_last_addr", 64'(wr_addr_log[2]), 64'd6);
    show(6'd5);
    check("verr_cnt_after", 64'(display_value), 64'd1);
    corrupt = 1'b0;

    // Length edges
    clear_log();
    send(32'h40); send(32'd0);
    check("len0_nwr", 64'(wr_addr_log.size()), 64'd0);
    show(6'd6);
    check("len0_state", 64'(display_value), 64'd0);
    send(32'h0); send(32'd100);
    show(6'd2);
    check("len100_left", 64'(display_value), 64'd16);
    for (int i = 0; i < 16; i++) send(32'h100 + 32'(i));
    check("len100_nwr", 64'(wr_addr_log.size()), 64'd16);
    if (wr_addr_log.size() == 16) begin
      check("len100_last_a", 64'(wr_addr_log[15]), 64'd15);
      check("len100_last_d", 64'(wr_data_log[15]), 64'h10F);
    end
    show(6'd6);
    check("len100_state", 64'(display_value), 64'd0);

    // Address wrap
    clear_log();
    send(32'hFFFFFFFC); send(32'd2); send(32'h11); send(32'h22);
    check("wrap_nwr", 64'(wr_addr_log.size()), 64'd2);
    if (wr_addr_log.size() == 2) begin
      check("wrap_a0", 64'(wr_addr_log[0]), 64'h3FFFFFFF);
      check("wrap_a1", 64'(wr_addr_log[1]), 64'd0);
    end
    show(6'd5);
    check("wrap_errcnt", 64'(display_value), 64'd1);

    // Dropped input during WRITE
    clear_log();
    send(32'h100); send(32'd2);
    @(negedge clk);
    input_valid = 1'b1; input_value = 32'h55;
    @(negedge clk);            // now in WRITE
    input_value = 32'h66;
    @(negedge clk);            // pulse seen in WRITE, now VERIFY
    input_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("drop_nwr", 64'(wr_addr_log.size()), 64'd1);
    show(6'd6);
    check("drop_state", 64'(display_value), 64'd2);
    send(32'h77);
    check("drop_nwr2", 64'(wr_addr_log.size()), 64'd2);
    if (wr_addr_log.size() == 2) begin
      check("drop_d0", 64'(wr_data_log[0]), 64'h55);
      check("drop_d1", 64'(wr_data_log[1]), 64'h77);
      check("drop_a1", 64'(wr_addr_log[1]), 64'h41);
    end

    // Mid-burst reset in VERIFY
    clear_log();
    send(32'h200); send(32'd2);
    @(negedge clk);
    input_valid = 1'b1; input_value = 32'h99;
    @(negedge clk);            // WRITE
    input_valid = 1'b0;
    @(negedge clk);            // VERIFY
    check("mrst_busy_pre", 64'(busy), 64'd1);
    resetn = 1'b0;
    @(negedge clk);
    check("mrst_we", 64'(ram_we), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_err", 64'(err), 64'd0);
    check("mrst_addr", 64'(ram_addr), 64'd0);
    check("mrst_wdata", 64'(ram_wdata), 64'd0);
    check("mrst_dvalid", 64'(display_valid), 64'd0);
    check("mrst_dvalue", 64'(display_value), 64'd0);
    check("mrst_committed", 64'(wr_addr_log.size()), 64'd1);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("mrst_state_valid", 64'(display_valid), 64'd1);
    check("mrst_state_val", 64'(display_value), 64'd0);
    show(6'd5);
    check("mrst_errcnt", 64'(display_value), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
